// File: rtl/data_arith_narrow.sv
`default_nettype none
// ============================================================================
// Module   : data_arith_narrow
// Purpose  : Pipelined multi-lane signed/unsigned width reducer with
//            saturate-or-wrap handling, overflow flags and status counters.
// Revision : 1.0 - initial release
// ============================================================================
module data_arith_narrow #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 4,
    parameter int LANES    = 2,
    parameter int STAGES   = 2,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0][IN_W-1:0]   in,
    input  logic                         in_valid,
    input  logic                         sign,
    output logic [LANES-1:0][OUT_W-1:0]  out,
    output logic                         out_valid,
    output logic [LANES-1:0]             ovf,
    output logic                         ovf_sticky,
    output logic [LANES-1:0][CNT_W-1:0]  ovf_count
);

    localparam logic [OUT_W-1:0] c_umax = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] c_smax = c_umax >> 1;
    localparam logic [OUT_W-1:0] c_smin = ~c_smax;
    localparam logic [CNT_W-1:0] c_cmax = {CNT_W{1'b1}};

    logic [LANES-1:0][OUT_W-1:0]              w_out;
    logic [LANES-1:0]                         w_ovf;

    logic [STAGES-1:0]                        r_valid;
    logic [STAGES-1:0][LANES-1:0][OUT_W-1:0]  r_out;
    logic [STAGES-1:0][LANES-1:0]             r_ovf;
    logic                                     r_sticky;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IN_W-OUT_W:0]   w_hi_s;
        logic [IN_W-OUT_W-1:0] w_hi_u;
        logic                  w_in_rng;
        logic                  w_neg;
        logic [CNT_W-1:0]      r_cnt;

        // Signed range holds when the discarded bits plus the new sign bit all agree.
        assign w_hi_s   = in[i][IN_W-1:OUT_W-1];
        assign w_hi_u   = in[i][IN_W-1:OUT_W];
        assign w_neg    = in[i][IN_W-1];
        assign w_in_rng = sign ? ((w_hi_s == '0) || (w_hi_s == '1)) : (w_hi_u == '0);

        assign w_ovf[i] = ~w_in_rng;
        assign w_out[i] = (w_in_rng || (SATURATE == 0)) ? in[i][OUT_W-1:0] :
                          (!sign ? c_umax : (w_neg ? c_smin : c_smax));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (out_valid && ovf[i] && (r_cnt != c_cmax)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign ovf_count[i] = r_cnt;
    end

    // Bubbles carry zeroed data so the outputs read 0 whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_out   <= '0;
            r_ovf   <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_out[0]   <= in_valid ? w_out : '0;
            r_ovf[0]   <= in_valid ? w_ovf : '0;
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_out[s]   <= r_out[s-1];
                r_ovf[s]   <= r_ovf[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (out_valid && (|ovf)) begin
            r_sticky <= 1'b1;
        end
    end

    assign out        = r_out[STAGES-1];
    assign out_valid  = r_valid[STAGES-1];
    assign ovf        = r_ovf[STAGES-1];
    assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_data_arith_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_arith_narrow
// Purpose  : Directed self-checking bench for data_arith_narrow, saturating
//            and wrapping variants driven in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_arith_narrow;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] in;
    logic            in_valid;
    logic            sign;

    logic [1:0][3:0] out_s, out_w;
    logic            vld_s, vld_w;
    logic [1:0]      ovf_s, ovf_w;
    logic            stk_s, stk_w;
    logic [1:0][1:0] cnt_s, cnt_w;

    int n_chk  = 0;
    int n_pass = 0;

    logic       vec_vld [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] vec_l0  [6] = '{8'h80, 8'h40, 8'h00, 8'h7F, 8'h90, 8'h10};
    logic [3:0] exp_l0  [6] = '{4'h8, 4'h7, 4'h0, 4'h7, 4'h8, 4'h7};

    always #5 clk = ~clk;

    data_arith_narrow #(
        .IN_W(8), .OUT_W(4), .LANES(2), .STAGES(2), .SATURATE(1), .CNT_W(2)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sign(sign),
        .out(out_s), .out_valid(vld_s), .ovf(ovf_s),
        .ovf_sticky(stk_s), .ovf_count(cnt_s)
    );

    data_arith_narrow #(
        .IN_W(8), .OUT_W(4), .LANES(2), .STAGES(2), .SATURATE(0), .CNT_W(2)
    ) u_dut_wrap (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sign(sign),
        .out(out_w), .out_valid(vld_w), .ovf(ovf_w),
        .ovf_sticky(stk_w), .ovf_count(cnt_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in       = '0;
        in_valid = 1'b0;
        sign     = 1'b1;

        // Reset
        step();
        step();
        check("rst_out",    32'(out_s), 32'h0);
        check("rst_valid",  32'(vld_s), 32'h0);
        check("rst_ovf",    32'(ovf_s), 32'h0);
        check("rst_sticky", 32'(stk_s), 32'h0);
        check("rst_count",  32'(cnt_s), 32'h0);
        rst = 1'b0;

        // Signed in-range round trip
        in = {8'hFA, 8'h05}; in_valid = 1'b1; sign = 1'b1;
        step();
        in_valid = 1'b0;
        check("rt_latency", 32'(vld_s), 32'h0);
        step();
        check("rt_valid", 32'(vld_s), 32'h1);
        check("rt_out",   32'(out_s), 32'hA5);
        check("rt_ovf",   32'(ovf_s), 32'h0);
        step();
        check("rt_bubble_valid", 32'(vld_s), 32'h0);
        check("rt_bubble_out",   32'(out_s), 32'h0);

        // Signed saturation vs wrap
        in = {8'h7F, 8'h80}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("ssat_out",    32'(out_s), 32'h78);
        check("ssat_ovf",    32'(ovf_s), 32'h3);
        check("swrap_out",   32'(out_w), 32'hF0);
        check("swrap_ovf",   32'(ovf_w), 32'h3);
        check("swrap_valid", 32'(vld_w), 32'h1);
        step();
        check("ssat_sticky",  32'(stk_s), 32'h1);
        check("ssat_count",   32'(cnt_s), 32'h5);
        check("swrap_sticky", 32'(stk_w), 32'h1);

        // Unsigned then signed back-to-back: sign must travel with its entry
        in = {8'h1F, 8'h0C}; in_valid = 1'b1; sign = 1'b0;
        step();
        sign = 1'b1;
        step();
        in_valid = 1'b0;
        check("uns_out",   32'(out_s), 32'hFC);
        check("uns_ovf",   32'(ovf_s), 32'h2);
        check("uwrap_out", 32'(out_w), 32'hFC);
        sign = 1'b0;
        step();
        check("sgn_out",   32'(out_s), 32'h77);
        check("sgn_ovf",   32'(ovf_s), 32'h3);
        check("swrap2_out", 32'(out_w), 32'hFC);
        step();
        check("mix_count",  32'(cnt_s), 32'hE);
        check("mix_countw", 32'(cnt_w), 32'hE);

        // Clear status before counter-saturation run
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("clr_count",  32'(cnt_s), 32'h0);
        check("clr_sticky", 32'(stk_s), 32'h0);

        // Counter saturation with a bubble, lane 0 overflowing, lane 1 in range
        sign = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            if (t < 6) begin
                in       = {8'h03, vec_l0[t]};
                in_valid = vec_vld[t];
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (t >= 1) begin
                check($sformatf("cs_valid%0d", t-1), 32'(vld_s), 32'(vec_vld[t-1]));
                check($sformatf("cs_out%0d", t-1), 32'(out_s),
                      vec_vld[t-1] ? {24'h0, 4'h3, exp_l0[t-1]} : 32'h0);
                check($sformatf("cs_ovf%0d", t-1), 32'(ovf_s),
                      vec_vld[t-1] ? 32'h1 : 32'h0);
            end
        end
        step();
        check("cs_count",  32'(cnt_s), 32'h3);
        check("cs_sticky", 32'(stk_s), 32'h1);

        // Reset with an overflowing entry at the output and another in flight
        in = {8'h80, 8'h80}; in_valid = 1'b1;
        step();
        step();
        check("rip_pre_valid", 32'(vld_s), 32'h1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("rip_valid",  32'(vld_s), 32'h0);
        check("rip_out",    32'(out_s), 32'h0);
        check("rip_count",  32'(cnt_s), 32'h0);
        check("rip_sticky", 32'(stk_s), 32'h0);
        step();
        check("rip_drop_valid", 32'(vld_s), 32'h0);
        check("rip_drop_count", 32'(cnt_s), 32'h0);

        // Next accepted entry appears two edges after acceptance
        in = {8'h05, 8'hFA}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_early", 32'(vld_s), 32'h0);
        step();
        check("post_valid", 32'(vld_s), 32'h1);
        check("post_out",   32'(out_s), 32'h5A);
        check("post_ovf",   32'(ovf_s), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
